// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART command-frame decoder.
package uart_frame_pkg;

  // Command opcodes carried in the OP byte of a frame.
  typedef enum logic [2:0] {
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_RUN   = 3'd3,
    OP_HALT  = 3'd4
  } op_t;

  // Frame parser states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_OUT
  } dec_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

  // True when the byte encodes one of the supported opcodes.
  function automatic logic is_known_op(input logic [7:0] b);
    return (b >= 8'd1) && (b <= 8'd4);
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags the cycle on which the limit is reached.
module uart_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  // Count idle cycles; a clear always wins, and the count parks at the limit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/uart_frame_decoder.sv
// Parses SYNC/OP/ADDR/DATA/CHK command frames from the UART byte stream and
// presents each good command on a valid/ready interface; bad frames are
// dropped with single-cycle error pulses.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter int          DATA_W         = 16,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int          TIMEOUT_CYCLES = 27000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic              rx_break,
  input  logic [7:0]        rx_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              err_chk,
  output logic              err_op,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              busy
);

  localparam int AB      = bytes_for_bits(ADDR_W);
  localparam int DB      = bytes_for_bits(DATA_W);
  localparam int CNT_MAX = (AB > DB) ? AB : DB;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(AB - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DB - 1);

  dec_state_t          state;
  logic [CW-1:0]       cnt;
  logic [7:0]          chk;
  logic [AB*8-1:0]     addr_buf;
  logic [DB*8-1:0]     data_buf;
  logic                timer_clear;
  logic                timer_enable;
  logic                timer_expired;
  logic                in_frame;
  logic                handshake;

  // The timer only runs while a frame is being collected; every byte restarts it.
  assign in_frame     = (state == ST_OPC) || (state == ST_ADDR) ||
                        (state == ST_DATA) || (state == ST_CHK);
  assign timer_clear  = rx_valid || (state == ST_IDLE) || (state == ST_OUT);
  assign timer_enable = in_frame;
  assign handshake    = cmd_valid && cmd_ready;

  uart_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Frame parser: walks the frame byte by byte, accumulating fields and the
  // running XOR, and holds the finished command until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      chk         <= '0;
      addr_buf    <= '0;
      data_buf    <= '0;
      cmd_op      <= '0;
      cmd_valid   <= 1'b0;
      err_chk     <= 1'b0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= ST_OPC;
            cnt   <= '0;
          end
        end

        ST_OPC, ST_ADDR, ST_DATA, ST_CHK: begin
          if (rx_valid && rx_break) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (rx_valid) begin
            case (state)
              ST_OPC: begin
                if (is_known_op(rx_data)) begin
                  cmd_op   <= rx_data[2:0];
                  chk      <= rx_data;
                  addr_buf <= '0;
                  data_buf <= '0;
                  state    <= ST_ADDR;
                  cnt      <= '0;
                end else begin
                  err_op <= 1'b1;
                  state  <= ST_IDLE;
                  cnt    <= '0;
                end
              end
              ST_ADDR: begin
                for (int i = 0; i < AB; i++) begin
                  if (cnt == CW'(i)) addr_buf[i*8 +: 8] <= rx_data;
                end
                chk <= chk ^ rx_data;
                if (cnt == ADDR_LAST) begin
                  state <= ST_DATA;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              ST_DATA: begin
                for (int i = 0; i < DB; i++) begin
                  if (cnt == CW'(i)) data_buf[i*8 +: 8] <= rx_data;
                end
                chk <= chk ^ rx_data;
                if (cnt == DATA_LAST) begin
                  state <= ST_CHK;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
              default: begin
                if (rx_data == chk) begin
                  cmd_valid <= 1'b1;
                  state     <= ST_OUT;
                end else begin
                  err_chk <= 1'b1;
                  state   <= ST_IDLE;
                end
                cnt <= '0;
              end
            endcase
          end else if (timer_expired) begin
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
            cnt         <= '0;
          end
        end

        ST_OUT: begin
          if (handshake) begin
            cmd_valid <= 1'b0;
            cnt       <= '0;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state <= ST_OPC;
            end else begin
              state <= ST_IDLE;
            end
          end else if (rx_valid) begin
            err_overrun <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign cmd_addr = addr_buf[ADDR_W-1:0];
  assign cmd_data = data_buf[DATA_W-1:0];
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: a table of whole frames plus
// hand-written sequences for hold, timeout, break, overrun and back-to-back.
module tb_uart_frame_decoder;

  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic        rx_break;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_chk;
  logic        err_op;
  logic        err_timeout;
  logic        err_overrun;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int chk_cnt  = 0;
  int op_cnt   = 0;
  int to_cnt   = 0;
  int ovr_cnt  = 0;
  int hs_cnt   = 0;

  uart_frame_decoder #(
    .ADDR_W(8),
    .DATA_W(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rx_valid    (rx_valid),
    .rx_break    (rx_break),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .err_chk     (err_chk),
    .err_op      (err_op),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Handshakes are counted at the edge; error pulses just after it, so a
  // pulse stuck high for more than one cycle shows up as an extra count.
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) hs_cnt++;
    #1;
    if (err_chk)     chk_cnt++;
    if (err_op)      op_cnt++;
    if (err_timeout) to_cnt++;
    if (err_overrun) ovr_cnt++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [0:7][7:0] bytes;
    int              len;
    logic            exp_valid;
    logic [2:0]      exp_op;
    logic [7:0]      exp_addr;
    logic [15:0]     exp_data;
    int              exp_chk;
    int              exp_op_err;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic brk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = data;
    rx_break = brk;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [0:7][7:0] bytes, input int len);
    for (int i = 0; i < len; i++) applyStimulus(bytes[i], 1'b0);
  endtask

  task automatic handshake_once();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  logic [0:7][7:0] f_write;
  logic [0:7][7:0] f_run;
  logic [0:7][7:0] f_read;

  initial begin
    int b_chk, b_op, b_to, b_ovr, b_hs, waited;

    f_write = {8'hA5, 8'h01, 8'h10, 8'h34, 8'h12, 8'h37, 8'h00, 8'h00};
    f_run   = {8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
    f_read  = {8'hA5, 8'h02, 8'hFF, 8'h00, 8'h00, 8'hFD, 8'h00, 8'h00};

    vecs[0] = '{bytes: f_write, len: 6, exp_valid: 1'b1, exp_op: 3'd1,
                exp_addr: 8'h10, exp_data: 16'h1234, exp_chk: 0, exp_op_err: 0};
    vecs[1] = '{bytes: f_read, len: 6, exp_valid: 1'b1, exp_op: 3'd2,
                exp_addr: 8'hFF, exp_data: 16'h0000, exp_chk: 0, exp_op_err: 0};
    vecs[2] = '{bytes: {8'hA5, 8'h04, 8'h00, 8'hCD, 8'hAB, 8'h62, 8'h00, 8'h00},
                len: 6, exp_valid: 1'b1, exp_op: 3'd4,
                exp_addr: 8'h00, exp_data: 16'hABCD, exp_chk: 0, exp_op_err: 0};
    vecs[3] = '{bytes: {8'hA5, 8'h01, 8'h10, 8'h34, 8'h12, 8'h38, 8'h00, 8'h00},
                len: 6, exp_valid: 1'b0, exp_op: 3'd0,
                exp_addr: 8'h00, exp_data: 16'h0000, exp_chk: 1, exp_op_err: 0};
    vecs[4] = '{bytes: {8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 2, exp_valid: 1'b0, exp_op: 3'd0,
                exp_addr: 8'h00, exp_data: 16'h0000, exp_chk: 0, exp_op_err: 1};
    vecs[5] = '{bytes: {8'h55, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03},
                len: 8, exp_valid: 1'b1, exp_op: 3'd3,
                exp_addr: 8'h00, exp_data: 16'h0000, exp_chk: 0, exp_op_err: 0};

    resetn    = 1'b0;
    rx_valid  = 1'b0;
    rx_break  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state.
    checkOutput("reset_outputs",
                {cmd_valid, cmd_op, cmd_addr, cmd_data, err_chk, err_op,
                 err_timeout, err_overrun, busy}, 32'h0);

    // Table of whole frames.
    foreach (vecs[v]) begin
      b_chk = chk_cnt; b_op = op_cnt; b_to = to_cnt; b_ovr = ovr_cnt;
      send_frame(vecs[v].bytes, vecs[v].len);
      checkOutput($sformatf("vec%0d_valid", v), 32'(cmd_valid), 32'(vecs[v].exp_valid));
      checkOutput($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_valid));
      checkOutput($sformatf("vec%0d_err_chk", v), chk_cnt - b_chk, vecs[v].exp_chk);
      checkOutput($sformatf("vec%0d_err_op", v), op_cnt - b_op, vecs[v].exp_op_err);
      checkOutput($sformatf("vec%0d_other_err", v), (to_cnt - b_to) + (ovr_cnt - b_ovr), 0);
      if (vecs[v].exp_valid) begin
        checkOutput($sformatf("vec%0d_op", v), 32'(cmd_op), 32'(vecs[v].exp_op));
        checkOutput($sformatf("vec%0d_addr", v), 32'(cmd_addr), 32'(vecs[v].exp_addr));
        checkOutput($sformatf("vec%0d_data", v), 32'(cmd_data), 32'(vecs[v].exp_data));
        handshake_once();
        checkOutput($sformatf("vec%0d_valid_after_hs", v), 32'(cmd_valid), 0);
        checkOutput($sformatf("vec%0d_busy_after_hs", v), 32'(busy), 0);
      end
    end

    // Command held while the consumer stalls, then exactly one handshake.
    send_frame(f_run, 6);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold%0d_valid", i), 32'(cmd_valid), 1);
      checkOutput($sformatf("hold%0d_op", i), 32'(cmd_op), 3);
      @(negedge clk);
    end
    b_hs = hs_cnt;
    handshake_once();
    checkOutput("hold_handshakes", hs_cnt - b_hs, 1);
    checkOutput("hold_busy_after", 32'(busy), 0);

    // Inter-byte timeout after a partial frame, then a clean frame.
    b_to = to_cnt;
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h10, 1'b0);
    waited = 0;
    while ((to_cnt == b_to) && (waited < TIMEOUT + 20)) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("timeout_pulse", to_cnt - b_to, 1);
    checkOutput("timeout_latency", waited, TIMEOUT);
    checkOutput("timeout_busy", 32'(busy), 0);
    send_frame(f_write, 6);
    checkOutput("post_timeout_valid", 32'(cmd_valid), 1);
    checkOutput("post_timeout_addr", 32'(cmd_addr), 32'h10);
    checkOutput("post_timeout_data", 32'(cmd_data), 32'h1234);
    handshake_once();

    // Break mid-frame aborts quietly; garbage in IDLE is ignored.
    b_chk = chk_cnt; b_op = op_cnt; b_to = to_cnt; b_ovr = ovr_cnt;
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h01, 1'b0);
    checkOutput("break_busy_before", 32'(busy), 1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("break_busy_after", 32'(busy), 0);
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("garbage_busy", 32'(busy), 0);
    checkOutput("break_no_errors",
                (chk_cnt - b_chk) + (op_cnt - b_op) + (to_cnt - b_to) + (ovr_cnt - b_ovr), 0);
    checkOutput("break_no_valid", 32'(cmd_valid), 0);

    // Byte arriving while a command is pending is dropped with an overrun.
    send_frame(f_write, 6);
    b_ovr = ovr_cnt;
    applyStimulus(8'h22, 1'b0);
    checkOutput("overrun_pulse", ovr_cnt - b_ovr, 1);
    checkOutput("overrun_valid_held", 32'(cmd_valid), 1);
    checkOutput("overrun_data_held", 32'(cmd_data), 32'h1234);
    handshake_once();

    // SYNC in the same cycle as the handshake starts the next frame.
    send_frame(f_read, 6);
    b_ovr = ovr_cnt;
    b_hs  = hs_cnt;
    @(negedge clk);
    rx_valid  = 1'b1;
    rx_data   = 8'hA5;
    cmd_ready = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    checkOutput("b2b_handshake", hs_cnt - b_hs, 1);
    checkOutput("b2b_valid_cleared", 32'(cmd_valid), 0);
    checkOutput("b2b_busy", 32'(busy), 1);
    checkOutput("b2b_no_overrun", ovr_cnt - b_ovr, 0);
    for (int i = 1; i < 6; i++) applyStimulus(f_write[i], 1'b0);
    checkOutput("b2b_next_valid", 32'(cmd_valid), 1);
    checkOutput("b2b_next_op", 32'(cmd_op), 1);
    checkOutput("b2b_next_addr", 32'(cmd_addr), 32'h10);
    checkOutput("b2b_next_data", 32'(cmd_data), 32'h1234);

    // Reset while a command is pending drops it.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("reset_pending_valid", 32'(cmd_valid), 0);
    checkOutput("reset_pending_busy", 32'(busy), 0);
    checkOutput("reset_pending_fields", {cmd_op, cmd_addr, cmd_data}, 32'h0);

    // Reset mid-frame returns to IDLE.
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h02, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("reset_midframe_busy", 32'(busy), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Consumes the byte stream produced by the UART receiver (valid/break/data, 8-bit payload).
- Parses fixed-length command frames and presents each decoded command on a valid/ready interface to the machine's host-control logic (memory load, run, halt, read-back request).
- Drops malformed, truncated or aborted frames and reports them with single-cycle error pulses.

Parameters:
- ADDR_W, 8: address field width in bits; the frame carries AB = ceil(ADDR_W/8) address bytes.
- DATA_W, 16: data field width in bits; the frame carries DB = ceil(DATA_W/8) data bytes.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 27000: maximum idle cycles between bytes inside a frame (1 ms at 27 MHz).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_break  in  1  BREAK indication, coincident with rx_valid
- rx_data  in  8  received byte
- cmd_valid  out  1  decoded command available
- cmd_ready  in  1  consumer accepts the command
- cmd_op  out  3  opcode: 1=WRITE, 2=READ, 3=RUN, 4=HALT
- cmd_addr  out  ADDR_W  decoded address
- cmd_data  out  DATA_W  decoded data
- err_chk  out  1  pulse: checksum mismatch
- err_op  out  1  pulse: unknown opcode
- err_timeout  out  1  pulse: inter-byte timeout
- err_overrun  out  1  pulse: byte dropped while a command is pending
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset (resetn) is synchronous and active-low.
- Reset values: state IDLE; all outputs 0; internal counters and accumulators 0.
- Frame format: SYNC, OP, AB address bytes, DB data bytes, CHK.
  - Address and data bytes arrive little-endian.
  - Bits above ADDR_W/DATA_W in the last byte are discarded.
  - CHK = XOR of OP, all address bytes and all data bytes.
  - Every opcode uses the full frame length; unused fields are still transmitted.
- States:
  - IDLE: rx_valid with data==SYNC_BYTE -> OPC; any other byte is ignored silently.
  - OPC: byte in 1..4 -> latch opcode, chk=byte, go ADDR. Any other value -> err_op pulse, go IDLE.
  - ADDR: shift the byte into cmd_addr at position cnt*8, chk^=byte; after AB bytes -> DATA.
  - DATA: same scheme into cmd_data; after DB bytes -> CHK.
  - CHK: byte==chk -> OUT with cmd_valid=1 on the next cycle (latency 1 cycle after the CHK strobe). Mismatch -> err_chk pulse, IDLE, cmd_valid stays 0.
  - OUT: cmd_valid held high; cmd_op/addr/data stable until the cycle with cmd_valid&cmd_ready, then the next state is IDLE.
- Byte counter: width clog2(max(AB,DB))+1; clears on every state change.
- Timeout:
  - Counter clears on each rx_valid and in IDLE/OUT; increments in OPC/ADDR/DATA/CHK.
  - On reaching TIMEOUT_CYCLES-1: err_timeout pulse, go IDLE.
- Break: rx_break=1 in OPC..CHK -> go IDLE, no error pulse, byte not processed. In IDLE and OUT, break is ignored.
- OUT with rx_valid and no handshake that cycle: byte dropped, err_overrun pulse.
- OUT with handshake and rx_valid in the same cycle:
  - The command is consumed and the byte is evaluated as in IDLE.
  - SYNC goes straight to OPC; no overrun is flagged.
- Error pulses are exactly one cycle; at most one error is raised per cycle.
- Reset asserted mid-frame or in OUT: immediate return to the reset values; the pending command is lost.

Decomposition:
- Package uart_frame_pkg holds:
  - opcode enum (OP_WRITE=1, OP_READ=2, OP_RUN=3, OP_HALT=4);
  - decoder state enum;
  - SYNC_BYTE default;
  - helper function computing byte count from bit width.
- One sub-module is natural: uart_timeout_timer (clear, enable, expired pulse; parameter TIMEOUT_CYCLES).

Test Plan:
- ADDR_W=8, DATA_W=16; bytes A5 01 10 34 12 37 -> one cycle after the last strobe, cmd_valid=1, op=1, addr=8'h10, data=16'h1234; cleared after a ready handshake.
- A5 03 00 00 00 03 with cmd_ready held 0 for 5 cycles, then 1 -> op=3 held stable throughout; one handshake; busy falls on the following cycle.
- A5 01 10 34 12 38 (bad CHK) -> err_chk single pulse, no cmd_valid. Then A5 07 -> err_op pulse, no cmd_valid.
- A5 01 10, then no bytes for TIMEOUT_CYCLES -> err_timeout pulse, busy=0. Following valid frame decodes correctly.
- A5 01, then break (rx_valid=1, rx_break=1, data 00) -> IDLE, no error. Garbage 55 FF in IDLE ignored.
- Command pending with ready=0, byte 22 arrives -> err_overrun. Next pending case: SYNC arrives in the same cycle as ready=1 -> command accepted and the new frame is parsed, with the next command matching its bytes.
